// File: rtl/bitserial_adder_if.sv
// Handshake and data bundle for bitserial_adder.
// The ovf signal exists only when BITSERIAL_ADD_OVF_EN is defined.
interface bitserial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef BITSERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
`ifdef BITSERIAL_ADD_OVF_EN
    input  ovf,
`endif
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
`ifdef BITSERIAL_ADD_OVF_EN
    output ovf,
`endif
    output busy, done, sum, cout
  );
endinterface

// File: rtl/bitserial_adder.sv
// Bit-serial adder: one full-adder slice plus carry flop, LSB first, WIDTH cycles per add.
// Define BITSERIAL_ADD_OVF_EN to add a registered two's-complement overflow output.
module bitserial_adder #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  bitserial_adder_if.slave   bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-1:0] sum_sr_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             bit_s;
  logic             carry_next;
  logic             last_bit;
  logic [WIDTH-1:0] sum_sr_next;

  assign bit_s       = a_sr_reg[0] ^ b_sr_reg[0] ^ carry_reg;
  assign carry_next  = (a_sr_reg[0] & b_sr_reg[0]) |
                       (a_sr_reg[0] & carry_reg)   |
                       (b_sr_reg[0] & carry_reg);
  assign sum_sr_next = {bit_s, sum_sr_reg[WIDTH-1:1]};
  assign last_bit    = (cnt_reg == CNT_W'(WIDTH - 1));

`ifdef BITSERIAL_ADD_OVF_EN
  logic ovf_reg;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      sum_sr_reg <= '0;
      sum_reg    <= '0;
      carry_reg  <= 1'b0;
      cout_reg   <= 1'b0;
      cnt_reg    <= '0;
`ifdef BITSERIAL_ADD_OVF_EN
      ovf_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            a_sr_reg  <= bus.a;
            b_sr_reg  <= bus.b;
            carry_reg <= bus.cin;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          a_sr_reg   <= {1'b0, a_sr_reg[WIDTH-1:1]};
          b_sr_reg   <= {1'b0, b_sr_reg[WIDTH-1:1]};
          sum_sr_reg <= sum_sr_next;
          carry_reg  <= carry_next;
          cnt_reg    <= cnt_reg + 1'b1;
          if (last_bit) begin
            sum_reg   <= sum_sr_next;
            cout_reg  <= carry_next;
`ifdef BITSERIAL_ADD_OVF_EN
            // carry_reg here is the carry into the MSB slice
            ovf_reg   <= carry_reg ^ carry_next;
`endif
            state_reg <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state_reg == RUN);
  assign bus.done = (state_reg == DONE);
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
`ifdef BITSERIAL_ADD_OVF_EN
  assign bus.ovf  = ovf_reg;
`endif
endmodule

// File: tb/tb_bitserial_adder.sv
// Randomized + directed bench for bitserial_adder against an arithmetic reference model.
// Honours BITSERIAL_ADD_OVF_EN when the RTL is built with it.
module tb_bitserial_adder;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  bit   check_en;

  bitserial_adder_if #(.WIDTH(WIDTH)) bus ();

  bitserial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining-cycle countdown plus plain integer arithmetic.
  int               m_left;
  bit               m_done;
  logic [WIDTH-1:0] m_sum, m_pend_sum;
  logic             m_cout, m_pend_cout;
  logic             m_ovf, m_pend_ovf;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0; m_done = 0; m_sum = '0; m_cout = 0; m_ovf = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1; m_sum = m_pend_sum; m_cout = m_pend_cout; m_ovf = m_pend_ovf;
      end
    end else begin
      m_done = 0;
      if (bus.start) begin
        logic [WIDTH:0] t;
        int sv;
        t  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
        sv = int'($signed(bus.a)) + int'($signed(bus.b)) + int'(bus.cin);
        m_pend_sum  = t[WIDTH-1:0];
        m_pend_cout = t[WIDTH];
        m_pend_ovf  = (sv > (2 ** (WIDTH - 1)) - 1) || (sv < -(2 ** (WIDTH - 1)));
        m_left      = WIDTH;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("busy", 32'(bus.busy), 32'(m_left > 0));
      check("done", 32'(bus.done), 32'(m_done));
      check("sum",  32'(bus.sum),  32'(m_sum));
      check("cout", 32'(bus.cout), 32'(m_cout));
`ifdef BITSERIAL_ADD_OVF_EN
      check("ovf",  32'(bus.ovf),  32'(m_ovf));
`endif
      if (bus.done)
        $display("[TB] result sum=%0h cout=%0b", bus.sum, bus.cout);
    end
  end

  task automatic launch(input logic [7:0] ta, input logic [7:0] tb2, input logic tc);
    @(negedge clk);
    bus.start = 1'b1; bus.a = ta; bus.b = tb2; bus.cin = tc;
  endtask

  // Waits for done; optionally injects an ignored start at RUN cycle 3 and checks the held sum.
  task automatic finish(input string name, input logic [7:0] es, input logic ec, input logic eo,
                        input bit inject, input logic [7:0] prev);
    int lat;
    bit seen;
    lat = 0; seen = 0;
    for (int i = 0; i < WIDTH + 4 && !seen; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (inject && i == 2) begin
        bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55;
        check({name, "_held_sum"}, 32'(bus.sum), 32'(prev));
      end
      if (bus.done) seen = 1;
      else if (bus.busy) lat++;
    end
    check({name, "_seen"}, 32'(seen), 32'd1);
    check({name, "_latency"}, lat, WIDTH);
    check({name, "_sum"}, 32'(bus.sum), 32'(es));
    check({name, "_cout"}, 32'(bus.cout), 32'(ec));
`ifdef BITSERIAL_ADD_OVF_EN
    check({name, "_ovf"}, 32'(bus.ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("[TB] unreachable");
`endif
  endtask

  initial begin
    bit saw_done;
    tests = 0; fails = 0; check_en = 0;
    rst_n = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (3) @(posedge clk);
    check_en = 1;
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_sum",  32'(bus.sum),  32'd0);

    launch(8'h0F, 8'h01, 1'b0); finish("add_0f_01", 8'h10, 1'b0, 1'b0, 0, 8'h00);
    launch(8'hFF, 8'h01, 1'b0); finish("add_ff_01", 8'h00, 1'b1, 1'b0, 0, 8'h00);
    launch(8'h7F, 8'h01, 1'b0); finish("add_7f_01", 8'h80, 1'b0, 1'b1, 0, 8'h00);
    launch(8'h00, 8'h00, 1'b1); finish("add_cin",   8'h01, 1'b0, 1'b0, 0, 8'h00);
    launch(8'hFF, 8'hFF, 1'b1); finish("add_ff_ff", 8'hFF, 1'b1, 1'b0, 0, 8'h00);
    launch(8'h12, 8'h34, 1'b0); finish("ignored",   8'h46, 1'b0, 1'b0, 1, 8'hFF);

    // Back-to-back: start held during the DONE cycle
    launch(8'h80, 8'h80, 1'b0); finish("b2b_first", 8'h00, 1'b1, 1'b1, 0, 8'h00);
    bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h02; bus.cin = 1'b0;
    finish("b2b_second", 8'h03, 1'b0, 1'b0, 0, 8'h00);

    // Reset abort at RUN cycle 4
    launch(8'h55, 8'h22, 1'b0);
    repeat (4) begin @(negedge clk); bus.start = 1'b0; end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_sum",  32'(bus.sum),  32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    saw_done = 0;
    repeat (WIDTH + 3) begin @(negedge clk); if (bus.done) saw_done = 1; end
    check("abort_no_done", 32'(saw_done), 32'd0);
    launch(8'h21, 8'h13, 1'b0); finish("after_abort", 8'h34, 1'b0, 1'b0, 0, 8'h00);

    // Random traffic: starts at any time, occasional reset
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.a     = WIDTH'($urandom);
      bus.b     = WIDTH'($urandom);
      bus.cin   = 1'($urandom);
      rst_n     = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    bus.start = 1'b0; rst_n = 1'b1;
    repeat (WIDTH + 3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bitserial_adder.md
Name: bitserial_adder

Overview:
- Bit-serial ripple adder. Adds two WIDTH-bit operands plus carry-in, one bit per clock, using a single full-adder slice and a carry flip-flop.
- Serves as the addition counterpart to the team's half-subtractor cells.
- Provides start/busy/done handshaking so a controller can launch an operation and collect the registered sum and carry-out.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  operand A; sampled on the accepting edge
- b  input  WIDTH  operand B; sampled on the accepting edge
- cin  input  1  carry-in; sampled on the accepting edge
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result is valid
- sum  output  WIDTH  registered result, a+b+cin mod 2^WIDTH
- cout  output  1  registered carry out of bit WIDTH-1

Behaviour:
- Reset: on a rising edge with rst_n=0, force state=IDLE and busy=0, done=0, sum=0, cout=0. Clear all internal shift registers, carry flop and counter. Reset overrides start and aborts any run in progress; no done is produced for an aborted run.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1, lasts one cycle.
- Accept:
  - start=1 at an edge while in IDLE or DONE loads a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, and moves to RUN.
  - start while in RUN is ignored; no queuing.
- RUN, each edge:
  - s = a_sr[0]^b_sr[0]^carry.
  - carry <= majority(a_sr[0], b_sr[0], carry).
  - a_sr and b_sr shift right by one.
  - s shifts into the MSB of the internal sum shift register.
  - cnt increments.
- Completion: on the edge where cnt==WIDTH-1:
  - Copy the final sum shift register (including this bit) to sum.
  - cout <= the new carry.
  - Go to DONE.
- DONE: on the next edge, go to IDLE, or to RUN if start=1.
- Latency: start accepted at edge T -> done high in the cycle after edge T+WIDTH. Exactly WIDTH cycles from the accepting edge to done rising. Throughput is one operation per WIDTH+1 cycles; back-to-back runs are allowed by asserting start during DONE.
- Output stability: sum and cout change only on the completion edge (or reset). During RUN they hold the previous result.
- Width rules:
  - cnt is $clog2(WIDTH) bits wide.
  - Arithmetic is unsigned modulo 2^WIDTH; the carry beyond bit WIDTH-1 appears only on cout.
- Operand inputs may change freely after the accepting edge; they have no effect until the next accept.

Optional Feature:
- Macro: BITSERIAL_ADD_OVF_EN.
- Defined:
  - Extra port ovf, output, 1 bit: registered two's-complement overflow.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - Captured on the completion edge alongside sum and cout.
  - Reset value 0; held until the next completion.
  - Internal: latch the carry before the final bit slice.
- Undefined: no ovf port and no overflow logic. All other behaviour is identical.

Test Plan:
- Reset, then WIDTH=8, a=0x0F, b=0x01, cin=0, start pulsed at edge T -> busy=1 for 8 cycles; done pulse after edge T+8; sum=0x10, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0 when BITSERIAL_ADD_OVF_EN is defined. a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0. a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start 0x12+0x34. At cycle 3 of RUN, pulse start with a=0xAA, b=0x55 -> second request ignored; result sum=0x46. During RUN, sum still shows the previous result.
- Start 0x80+0x80. Hold start=1 during the DONE cycle with a=0x01, b=0x02 -> first result sum=0x00, cout=1. Second run starts with no IDLE gap; next done shows sum=0x03.
- Start a run, drive rst_n=0 at RUN cycle 4 for one edge -> outputs all 0, state IDLE, no done pulse. A fresh start afterwards produces a correct result.
